// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and default width for the interval timer.
package counter_pkg;

    localparam int DEFAULT_CNT_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/counter_nbit_ce.sv
// rtl/counter_nbit_ce.sv - n-bit up-counter register with synchronous clear and count enable.
module counter_nbit_ce
    import counter_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    // Clear wins over enable so a restart or wrap never increments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/counter_nbit_ctrl.sv
// rtl/counter_nbit_ctrl.sv - interval-timer controller: start/stop/hold, terminal detect, one-shot or reload.
module counter_nbit_ctrl
    import counter_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 hold,
    input  logic                 mode_reload,
    input  logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 busy,
    output logic                 done
);

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_period_q;
    logic                 r_reload_q;

    state_t               w_state_nxt;
    logic                 w_clr;
    logic                 w_en;
    logic                 w_done_nxt;
    logic                 w_load;
    logic                 w_start_ok;
    logic                 w_terminal;
    logic [CNT_WIDTH-1:0] w_count;

    assign w_start_ok = start && (period != '0);
    assign w_terminal = (w_count == r_period_q);

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        w_load      = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!hold) begin
                        if (w_terminal) begin
                            w_done_nxt = 1'b1;
                            if (r_reload_q) begin
                                w_clr = 1'b1;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_en = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                end
            endcase
        end
    end

    // busy and done are registered next to the state so outputs never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_period_q <= '0;
            r_reload_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_period_q <= period;
                r_reload_q <= mode_reload;
            end
        end
    end

    counter_nbit_ce #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_count)
    );

    assign counter = w_count;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_counter_nbit_ctrl.sv
// tb/tb_counter_nbit_ctrl.sv - directed and randomized self-checking bench for counter_nbit_ctrl.
module tb_counter_nbit_ctrl;

    localparam int W = 3;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         stop;
    logic         hold;
    logic         mode_reload;
    logic [W-1:0] period;
    logic [W-1:0] counter;
    logic         busy;
    logic         done;

    int n_checks;
    int n_errors;

    // Reference timer: "active" means a timing run is in progress; elapsed ticks in m_cnt.
    bit m_active;
    int m_cnt;
    int m_per;
    bit m_rel;
    bit m_done;

    counter_nbit_ctrl #(.CNT_WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .mode_reload (mode_reload),
        .period      (period),
        .counter     (counter),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_cnt    = 0;
        m_per    = 0;
        m_rel    = 0;
        m_done   = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (stop) begin
            m_active = 0;
            m_cnt    = 0;
        end else if (!m_active) begin
            if (start && period != 0) begin
                m_active = 1;
                m_per    = int'(period);
                m_rel    = mode_reload;
                m_cnt    = 0;
            end
        end else if (!hold) begin
            if (m_cnt < m_per) begin
                m_cnt = m_cnt + 1;
            end else begin
                m_done = 1;
                if (m_rel) m_cnt = 0;
                else m_active = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("counter", int'(counter), m_cnt);
        check_eq("busy", int'(busy), int'(m_active));
        check_eq("done", int'(done), int'(m_done));
    endtask

    task automatic set_in(input bit s, input bit p, input bit h, input bit m, input int per);
        start       = s;
        stop        = p;
        hold        = h;
        mode_reload = m;
        period      = W'(per);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        set_in(0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_counter", int'(counter), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        reset_n = 1'b1;

        // Auto-reload, period 3: 0,1,2,3,0,1,2,3 with done as the count returns to 0.
        set_in(1, 0, 0, 1, 3);
        step();
        check_eq("rl_first_cnt", int'(counter), 0);
        check_eq("rl_first_busy", int'(busy), 1);
        set_in(0, 0, 0, 0, 6);
        for (int i = 1; i < 8; i++) begin
            step();
            check_eq("rl_cnt", int'(counter), i % 4);
            check_eq("rl_done", int'(done), int'(i % 4 == 0));
            check_eq("rl_busy", int'(busy), 1);
        end
        set_in(0, 1, 0, 0, 0);
        step();

        // One-shot, period 2.
        set_in(1, 0, 0, 0, 2);
        step();
        set_in(0, 0, 0, 1, 5);
        step();
        step();
        check_eq("os_cnt2", int'(counter), 2);
        step();
        check_eq("os_exit_done", int'(done), 1);
        check_eq("os_exit_busy", int'(busy), 0);
        check_eq("os_exit_cnt", int'(counter), 2);
        step();
        check_eq("os_after_done", int'(done), 0);
        check_eq("os_hold_cnt", int'(counter), 2);
        set_in(1, 0, 0, 0, 2);
        step();
        check_eq("os_restart_cnt", int'(counter), 0);
        check_eq("os_restart_busy", int'(busy), 1);
        set_in(0, 1, 0, 0, 0);
        step();

        // Hold for three cycles at counter 1.
        set_in(1, 0, 0, 1, 3);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_cnt", int'(counter), 1);
            check_eq("hold_done", int'(done), 0);
        end
        set_in(0, 0, 0, 0, 0);
        step();
        check_eq("hold_res2", int'(counter), 2);
        step();
        check_eq("hold_res3", int'(counter), 3);
        step();
        check_eq("hold_done_after", int'(done), 1);
        set_in(0, 1, 0, 0, 0);
        step();

        // Stop coinciding with terminal count, period 5.
        set_in(1, 0, 0, 0, 5);
        step();
        set_in(0, 0, 0, 0, 5);
        repeat (5) step();
        check_eq("stop_pre_cnt", int'(counter), 5);
        set_in(0, 1, 0, 0, 5);
        step();
        check_eq("stop_cnt", int'(counter), 0);
        check_eq("stop_busy", int'(busy), 0);
        check_eq("stop_done", int'(done), 0);

        // Start with period 0 is ignored.
        set_in(1, 0, 0, 1, 0);
        step();
        step();
        check_eq("p0_busy", int'(busy), 0);
        check_eq("p0_done", int'(done), 0);

        // Asynchronous reset mid-count at counter 4, period 7.
        set_in(1, 0, 0, 0, 7);
        step();
        set_in(0, 0, 0, 0, 7);
        repeat (4) step();
        check_eq("ar_pre_cnt", int'(counter), 4);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_cnt", int'(counter), 0);
        check_eq("ar_busy", int'(busy), 0);
        check_eq("ar_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        check_eq("ar_idle_busy", int'(busy), 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                   $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
